// File: rtl/bp_pkg.sv
// +----------------------------------------------------------------------------+
// | bp_pkg: shared defaults, counter constants and update actions for          |
// | branch_predictor.                                          Revision: 1.0   |
// +----------------------------------------------------------------------------+
`default_nettype none

package bp_pkg;

  localparam int unsigned c_xlen_default     = 64;
  localparam int unsigned c_entries_default  = 16;
  localparam int unsigned c_ctr_bits_default = 2;

  localparam logic [c_ctr_bits_default-1:0] c_weak_taken     = 2'b10;
  localparam logic [c_ctr_bits_default-1:0] c_weak_not_taken = 2'b01;

  // Width-generic forms of the two constants above.
  function automatic int unsigned weak_taken_val(input int unsigned bits);
    return 32'd1 << (bits - 1);
  endfunction

  function automatic int unsigned weak_not_taken_val(input int unsigned bits);
    return (32'd1 << (bits - 1)) - 32'd1;
  endfunction

  typedef enum logic [1:0] {
    ACT_NONE  = 2'd0,
    ACT_TRAIN = 2'd1,
    ACT_ALLOC = 2'd2,
    ACT_JUMP  = 2'd3
  } upd_act_e;

endpackage

`default_nettype wire

// File: rtl/branch_predictor_if.sv
// +----------------------------------------------------------------------------+
// | branch_predictor_if: fetch lookup and resolved-update bus.                 |
// |                                                            Revision: 1.0   |
// +----------------------------------------------------------------------------+
`default_nettype none

interface branch_predictor_if #(
  parameter int unsigned XLEN = bp_pkg::c_xlen_default
);
  logic [XLEN-1:0] fetch_pc;
  logic            pred_hit;
  logic            pred_taken;
  logic [XLEN-1:0] pred_target;

  logic            upd_valid;
  logic [XLEN-1:0] upd_pc;
  logic            upd_is_jump;
  logic            upd_taken;
  logic [XLEN-1:0] upd_target;
  logic            upd_pred_taken;
  logic [XLEN-1:0] upd_pred_target;
  logic            upd_mispredict;

  modport master (
    output fetch_pc, upd_valid, upd_pc, upd_is_jump, upd_taken, upd_target,
           upd_pred_taken, upd_pred_target,
    input  pred_hit, pred_taken, pred_target, upd_mispredict
  );

  modport slave (
    input  fetch_pc, upd_valid, upd_pc, upd_is_jump, upd_taken, upd_target,
           upd_pred_taken, upd_pred_target,
    output pred_hit, pred_taken, pred_target, upd_mispredict
  );
endinterface

`default_nettype wire

// File: rtl/sat_counter.sv
// +----------------------------------------------------------------------------+
// | sat_counter: saturating up/down counter with set-max and load.             |
// |                                                            Revision: 1.0   |
// +----------------------------------------------------------------------------+
`default_nettype none

module sat_counter #(
  parameter int unsigned      WIDTH   = 2,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  wire logic             clk,
  input  wire logic             reset,
  input  wire logic             inc,
  input  wire logic             dec,
  input  wire logic             set_max,
  input  wire logic             load,
  input  wire logic [WIDTH-1:0] load_val,
  output logic      [WIDTH-1:0] count
);

  localparam logic [WIDTH-1:0] c_max = '1;

  logic [WIDTH-1:0] r_count;
  logic [WIDTH-1:0] w_count_nxt;

  always_comb begin
    w_count_nxt = r_count;
    if (set_max)
      w_count_nxt = c_max;
    else if (load)
      w_count_nxt = load_val;
    else if (inc && (r_count != c_max))
      w_count_nxt = r_count + 1'b1;
    else if (dec && (r_count != '0))
      w_count_nxt = r_count - 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      r_count <= RST_VAL;
    else
      r_count <= w_count_nxt;
  end

  assign count = r_count;

endmodule

`default_nettype wire

// File: rtl/branch_predictor.sv
// +----------------------------------------------------------------------------+
// | branch_predictor: direct-mapped BTB with per-entry saturating counters.    |
// |                                                            Revision: 1.0   |
// +----------------------------------------------------------------------------+
`default_nettype none

module branch_predictor
  import bp_pkg::*;
#(
  parameter int unsigned XLEN     = c_xlen_default,
  parameter int unsigned ENTRIES  = c_entries_default,
  parameter int unsigned CTR_BITS = c_ctr_bits_default
) (
  input  wire logic        clk,
  input  wire logic        reset,
  input  wire logic        bp_clear,
  branch_predictor_if.slave bp,
  output logic      [31:0] stat_updates,
  output logic      [31:0] stat_mispredicts
);

  localparam int unsigned c_idx   = $clog2(ENTRIES);
  localparam int unsigned c_tag_w = XLEN - c_idx - 2;
  localparam logic [CTR_BITS-1:0] c_ctr_weak_taken     = CTR_BITS'(weak_taken_val(CTR_BITS));
  localparam logic [CTR_BITS-1:0] c_ctr_weak_not_taken = CTR_BITS'(weak_not_taken_val(CTR_BITS));

  logic                r_valid  [ENTRIES];
  logic [c_tag_w-1:0]  r_tag    [ENTRIES];
  logic [XLEN-1:0]     r_target [ENTRIES];
  logic [CTR_BITS-1:0] w_ctr    [ENTRIES];

  logic [c_idx-1:0]   w_f_idx, w_u_idx;
  logic [c_tag_w-1:0] w_f_tag, w_u_tag;
  logic               w_u_hit;
  logic               w_wr_target;
  upd_act_e           w_act;
  logic               w_unused;

  assign w_f_idx  = bp.fetch_pc[c_idx+1:2];
  assign w_f_tag  = bp.fetch_pc[XLEN-1:c_idx+2];
  assign w_u_idx  = bp.upd_pc[c_idx+1:2];
  assign w_u_tag  = bp.upd_pc[XLEN-1:c_idx+2];
  assign w_unused = ^{bp.fetch_pc[1:0], bp.upd_pc[1:0]};

  assign bp.pred_hit    = r_valid[w_f_idx] && (r_tag[w_f_idx] == w_f_tag);
  assign bp.pred_taken  = bp.pred_hit && w_ctr[w_f_idx][CTR_BITS-1];
  assign bp.pred_target = bp.pred_taken ? r_target[w_f_idx] : bp.fetch_pc + XLEN'(4);

  assign bp.upd_mispredict = bp.upd_valid &&
                             ((bp.upd_taken != bp.upd_pred_taken) ||
                              (bp.upd_taken && (bp.upd_target != bp.upd_pred_target)));

  assign w_u_hit = r_valid[w_u_idx] && (r_tag[w_u_idx] == w_u_tag);

  // A clear swallows any simultaneous update so the table ends up fully invalid.
  always_comb begin
    w_act = ACT_NONE;
    if (bp.upd_valid && !bp_clear) begin
      if (bp.upd_is_jump)
        w_act = ACT_JUMP;
      else if (w_u_hit)
        w_act = ACT_TRAIN;
      else if (bp.upd_taken)
        w_act = ACT_ALLOC;
    end
  end

  assign w_wr_target = (w_act == ACT_JUMP) || (w_act == ACT_ALLOC) ||
                       ((w_act == ACT_TRAIN) && bp.upd_taken);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < int'(ENTRIES); i++) r_valid[i] <= 1'b0;
    end else if (bp_clear) begin
      for (int i = 0; i < int'(ENTRIES); i++) r_valid[i] <= 1'b0;
    end else if ((w_act == ACT_JUMP) || (w_act == ACT_ALLOC)) begin
      r_valid[w_u_idx] <= 1'b1;
    end
  end

  // Tag and target are qualified by valid, so they need no reset.
  always_ff @(posedge clk) begin
    if ((w_act == ACT_JUMP) || (w_act == ACT_ALLOC))
      r_tag[w_u_idx] <= w_u_tag;
    if (w_wr_target)
      r_target[w_u_idx] <= bp.upd_target;
  end

  for (genvar gi = 0; gi < ENTRIES; gi++) begin : g_entry
    logic w_sel;
    assign w_sel = (w_u_idx == c_idx'(gi));

    sat_counter #(
      .WIDTH   (CTR_BITS),
      .RST_VAL (c_ctr_weak_not_taken)
    ) u_ctr (
      .clk      (clk),
      .reset    (reset),
      .inc      (w_sel && (w_act == ACT_TRAIN) && bp.upd_taken),
      .dec      (w_sel && (w_act == ACT_TRAIN) && !bp.upd_taken),
      .set_max  (w_sel && (w_act == ACT_JUMP)),
      .load     (w_sel && (w_act == ACT_ALLOC)),
      .load_val (c_ctr_weak_taken),
      .count    (w_ctr[gi])
    );
  end

  sat_counter #(
    .WIDTH   (32),
    .RST_VAL ('0)
  ) u_stat_upd (
    .clk      (clk),
    .reset    (reset),
    .inc      (bp.upd_valid),
    .dec      (1'b0),
    .set_max  (1'b0),
    .load     (1'b0),
    .load_val ('0),
    .count    (stat_updates)
  );

  sat_counter #(
    .WIDTH   (32),
    .RST_VAL ('0)
  ) u_stat_mis (
    .clk      (clk),
    .reset    (reset),
    .inc      (bp.upd_mispredict),
    .dec      (1'b0),
    .set_max  (1'b0),
    .load     (1'b0),
    .load_val ('0),
    .count    (stat_mispredicts)
  );

endmodule

`default_nettype wire

// File: tb/tb_branch_predictor.sv
// +----------------------------------------------------------------------------+
// | tb_branch_predictor: directed vector table plus hand-written sequences.    |
// |                                                            Revision: 1.0   |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_branch_predictor;

  logic        clk;
  logic        rst_n;
  logic        bp_clear;
  logic [31:0] stat_updates;
  logic [31:0] stat_mispredicts;

  int total = 0;
  int bad   = 0;

  branch_predictor_if #(.XLEN(64)) bp_bus ();

  branch_predictor #(
    .XLEN     (64),
    .ENTRIES  (16),
    .CTR_BITS (2)
  ) dut (
    .clk              (clk),
    .reset            (rst_n),
    .bp_clear         (bp_clear),
    .bp               (bp_bus),
    .stat_updates     (stat_updates),
    .stat_mispredicts (stat_mispredicts)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        uv;
    logic [63:0] upc;
    logic        jmp;
    logic        tk;
    logic [63:0] tgt;
    logic        ptk;
    logic [63:0] ptgt;
    logic        emis;
    logic [63:0] lpc;
    logic        ehit;
    logic        etk;
    logic [63:0] etgt;
  } vec_t;

  vec_t vecs [16];

  function automatic vec_t mk(input logic uv, input logic [63:0] upc, input logic jmp,
                              input logic tk, input logic [63:0] tgt, input logic ptk,
                              input logic [63:0] ptgt, input logic emis, input logic [63:0] lpc,
                              input logic ehit, input logic etk, input logic [63:0] etgt);
    vec_t v;
    v.uv = uv; v.upc = upc; v.jmp = jmp; v.tk = tk; v.tgt = tgt; v.ptk = ptk;
    v.ptgt = ptgt; v.emis = emis; v.lpc = lpc; v.ehit = ehit; v.etk = etk; v.etgt = etgt;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic set_upd(input logic uv, input logic [63:0] pc, input logic jmp, input logic tk,
                         input logic [63:0] tgt, input logic ptk, input logic [63:0] ptgt);
    bp_bus.upd_valid       = uv;
    bp_bus.upd_pc          = pc;
    bp_bus.upd_is_jump     = jmp;
    bp_bus.upd_taken       = tk;
    bp_bus.upd_target      = tgt;
    bp_bus.upd_pred_taken  = ptk;
    bp_bus.upd_pred_target = ptgt;
  endtask

  task automatic upd(input logic [63:0] pc, input logic jmp, input logic tk, input logic [63:0] tgt,
                     input logic ptk, input logic [63:0] ptgt);
    @(negedge clk);
    set_upd(1'b1, pc, jmp, tk, tgt, ptk, ptgt);
    @(posedge clk);
    #1;
    bp_bus.upd_valid = 1'b0;
  endtask

  task automatic look(input string name, input logic [63:0] pc, input logic ehit,
                      input logic etk, input logic [63:0] etgt);
    bp_bus.fetch_pc = pc;
    #1;
    chk({name, ".hit"},    {63'd0, bp_bus.pred_hit},   {63'd0, ehit});
    chk({name, ".taken"},  {63'd0, bp_bus.pred_taken}, {63'd0, etk});
    chk({name, ".target"}, bp_bus.pred_target,         etgt);
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int exp_upd;
    int exp_mis;
    logic [31:0] prev_upd;

    rst_n    = 1'b0;
    bp_clear = 1'b0;
    bp_bus.fetch_pc = 64'h100;
    set_upd(1'b0, 64'h0, 1'b0, 1'b0, 64'h0, 1'b0, 64'h0);
    #12;
    chk("reset.stat_upd", {32'd0, stat_updates}, 64'd0);
    chk("reset.stat_mis", {32'd0, stat_mispredicts}, 64'd0);
    rst_n = 1'b1;

    //            uv    upc                     jmp   tk    tgt           ptk   ptgt       emis  lpc                     hit   tk    tgt
    vecs[0]  = mk(1'b0, 64'h100,                1'b0, 1'b0, 64'h0,        1'b0, 64'h0,     1'b0, 64'h100,                1'b0, 1'b0, 64'h104);
    vecs[1]  = mk(1'b1, 64'h100,                1'b0, 1'b1, 64'h80,       1'b0, 64'h0,     1'b1, 64'h100,                1'b1, 1'b1, 64'h80);
    vecs[2]  = mk(1'b1, 64'h100,                1'b0, 1'b0, 64'h0,        1'b1, 64'h80,    1'b1, 64'h100,                1'b1, 1'b0, 64'h104);
    vecs[3]  = mk(1'b1, 64'h100,                1'b0, 1'b0, 64'h0,        1'b0, 64'h0,     1'b0, 64'h100,                1'b1, 1'b0, 64'h104);
    vecs[4]  = mk(1'b1, 64'h100,                1'b0, 1'b0, 64'h0,        1'b0, 64'h0,     1'b0, 64'h100,                1'b1, 1'b0, 64'h104);
    vecs[5]  = mk(1'b1, 64'h100,                1'b0, 1'b1, 64'h80,       1'b0, 64'h0,     1'b1, 64'h100,                1'b1, 1'b0, 64'h104);
    vecs[6]  = mk(1'b1, 64'h100,                1'b0, 1'b1, 64'h80,       1'b0, 64'h0,     1'b1, 64'h100,                1'b1, 1'b1, 64'h80);
    vecs[7]  = mk(1'b1, 64'h140,                1'b0, 1'b1, 64'h300,      1'b0, 64'h0,     1'b1, 64'h100,                1'b0, 1'b0, 64'h104);
    vecs[8]  = mk(1'b0, 64'h140,                1'b0, 1'b1, 64'h999,      1'b0, 64'h0,     1'b0, 64'h140,                1'b1, 1'b1, 64'h300);
    vecs[9]  = mk(1'b1, 64'h184,                1'b0, 1'b0, 64'h0,        1'b0, 64'h0,     1'b0, 64'h184,                1'b0, 1'b0, 64'h188);
    vecs[10] = mk(1'b1, 64'h188,                1'b1, 1'b1, 64'h1000,     1'b1, 64'h1000,  1'b0, 64'h188,                1'b1, 1'b1, 64'h1000);
    vecs[11] = mk(1'b1, 64'h188,                1'b0, 1'b0, 64'h0,        1'b1, 64'h1000,  1'b1, 64'h188,                1'b1, 1'b1, 64'h1000);
    vecs[12] = mk(1'b1, 64'h188,                1'b0, 1'b1, 64'h2000,     1'b1, 64'h1000,  1'b1, 64'h188,                1'b1, 1'b1, 64'h2000);
    vecs[13] = mk(1'b1, 64'h184,                1'b0, 1'b1, 64'h80,       1'b1, 64'h90,    1'b1, 64'h184,                1'b1, 1'b1, 64'h80);
    vecs[14] = mk(1'b1, 64'h8000000000000100,   1'b0, 1'b1, 64'h44,       1'b0, 64'h0,     1'b1, 64'h140,                1'b0, 1'b0, 64'h144);
    vecs[15] = mk(1'b0, 64'h0,                  1'b0, 1'b0, 64'h0,        1'b0, 64'h0,     1'b0, 64'h8000000000000100,   1'b1, 1'b1, 64'h44);

    exp_upd = 0;
    exp_mis = 0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      set_upd(vecs[i].uv, vecs[i].upc, vecs[i].jmp, vecs[i].tk, vecs[i].tgt, vecs[i].ptk, vecs[i].ptgt);
      #1;
      chk($sformatf("vec%0d.mispredict", i), {63'd0, bp_bus.upd_mispredict}, {63'd0, vecs[i].emis});
      if (vecs[i].uv)   exp_upd++;
      if (vecs[i].emis) exp_mis++;
      @(posedge clk);
      #1;
      bp_bus.upd_valid = 1'b0;
      look($sformatf("vec%0d", i), vecs[i].lpc, vecs[i].ehit, vecs[i].etk, vecs[i].etgt);
    end
    chk("vec.stat_upd", {32'd0, stat_updates},     64'(exp_upd));
    chk("vec.stat_mis", {32'd0, stat_mispredicts}, 64'(exp_mis));

    // Lookup in the same cycle as an update to that index sees the old entry.
    @(negedge clk);
    bp_bus.fetch_pc = 64'h188;
    set_upd(1'b1, 64'h188, 1'b1, 1'b1, 64'h3000, 1'b1, 64'h2000);
    #1;
    chk("same_cycle.old_target", bp_bus.pred_target, 64'h2000);
    @(posedge clk);
    #1;
    bp_bus.upd_valid = 1'b0;
    look("same_cycle.new", 64'h188, 1'b1, 1'b1, 64'h3000);

    // Counter saturates high, then walks down one step per not-taken.
    pulse_reset();
    look("sat.empty", 64'h200, 1'b0, 1'b0, 64'h204);
    for (int i = 0; i < 5; i++) upd(64'h200, 1'b0, 1'b1, 64'h40, 1'b0, 64'h0);
    upd(64'h200, 1'b0, 1'b0, 64'h0, 1'b1, 64'h40);
    look("sat.nt1", 64'h200, 1'b1, 1'b1, 64'h40);
    upd(64'h200, 1'b0, 1'b0, 64'h0, 1'b1, 64'h40);
    look("sat.nt2", 64'h200, 1'b1, 1'b0, 64'h204);

    // Statistics saturation.
    @(negedge clk);
    force dut.u_stat_upd.r_count = 32'hFFFF_FFFE;
    force dut.u_stat_mis.r_count = 32'hFFFF_FFFE;
    #1;
    release dut.u_stat_upd.r_count;
    release dut.u_stat_mis.r_count;
    @(negedge clk);
    set_upd(1'b1, 64'h300, 1'b0, 1'b1, 64'h80, 1'b1, 64'h90);
    #1;
    chk("stat.mispredict", {63'd0, bp_bus.upd_mispredict}, 64'd1);
    @(posedge clk);
    #1;
    chk("stat.upd_max", {32'd0, stat_updates},     64'hFFFF_FFFF);
    chk("stat.mis_max", {32'd0, stat_mispredicts}, 64'hFFFF_FFFF);
    @(posedge clk);
    #1;
    bp_bus.upd_valid = 1'b0;
    chk("stat.upd_hold", {32'd0, stat_updates},     64'hFFFF_FFFF);
    chk("stat.mis_hold", {32'd0, stat_mispredicts}, 64'hFFFF_FFFF);

    // Reset pulsed during an update clears at once; the next update lands.
    @(negedge clk);
    bp_bus.fetch_pc = 64'h300;
    set_upd(1'b1, 64'h184, 1'b0, 1'b1, 64'h600, 1'b0, 64'h0);
    #1;
    chk("rst.pre_hit", {63'd0, bp_bus.pred_hit}, 64'd1);
    rst_n = 1'b0;
    #1;
    chk("rst.hit",      {63'd0, bp_bus.pred_hit},   64'd0);
    chk("rst.taken",    {63'd0, bp_bus.pred_taken}, 64'd0);
    chk("rst.target",   bp_bus.pred_target,         64'h304);
    chk("rst.stat_upd", {32'd0, stat_updates},      64'd0);
    chk("rst.stat_mis", {32'd0, stat_mispredicts},  64'd0);
    rst_n = 1'b1;
    bp_bus.upd_target = 64'h500;
    @(posedge clk);
    #1;
    bp_bus.upd_valid = 1'b0;
    look("rst.after", 64'h184, 1'b1, 1'b1, 64'h500);
    look("rst.old_gone", 64'h300, 1'b0, 1'b0, 64'h304);
    chk("rst.stat_after", {32'd0, stat_updates}, 64'd1);

    // Clear beats a simultaneous update and keeps statistics.
    upd(64'h100, 1'b0, 1'b1, 64'h80, 1'b0, 64'h0);
    look("clr.pre", 64'h100, 1'b1, 1'b1, 64'h80);
    prev_upd = stat_updates;
    @(negedge clk);
    bp_clear = 1'b1;
    set_upd(1'b1, 64'h188, 1'b0, 1'b1, 64'h700, 1'b0, 64'h0);
    @(posedge clk);
    #1;
    bp_clear = 1'b0;
    bp_bus.upd_valid = 1'b0;
    look("clr.e100", 64'h100, 1'b0, 1'b0, 64'h104);
    look("clr.e188", 64'h188, 1'b0, 1'b0, 64'h18c);
    look("clr.e184", 64'h184, 1'b0, 1'b0, 64'h188);
    chk("clr.stat_upd", {32'd0, stat_updates}, {32'd0, prev_upd + 32'd1});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
